// File: rtl/i2c_target_engine_if.sv
// Register-file side of the I2C target engine: received bytes,
// transmit byte request and bus-status pulses.
interface i2c_target_engine_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_first_o;
    logic [7:0] tx_data_i;
    logic       tx_req_o;
    logic       busy_o;
    logic       stop_o;

    modport master (
        output rx_data_o, rx_valid_o, rx_first_o,
        output tx_req_o, busy_o, stop_o,
        input  tx_data_i
    );

    modport slave (
        input  rx_data_o, rx_valid_o, rx_first_o,
        input  tx_req_o, busy_o, stop_o,
        output tx_data_i
    );
endinterface

// File: rtl/i2c_target_engine.sv
// I2C target byte engine: START/STOP detect, address match with ACK,
// byte receive to and byte transmit from a register file. SDA open drain.
module i2c_target_engine #(
    parameter logic [6:0] ADDRESS     = 7'h40,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   scl_i,
    inout  wire                    sda_io,
    i2c_target_engine_if.master    bus_if
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX,
        S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic r_scl_d, r_sda_d;
    state_t r_state, w_state_n;
    logic [2:0] r_bit, w_bit_n;
    logic [7:0] r_shift, w_shift_n;
    logic [6:0] r_tx_sh, w_tx_sh_n;
    logic [7:0] r_rx_data, w_rx_data_n;
    logic r_done, w_done_n;
    logic r_sda_low, w_sda_low_n;
    logic r_busy, w_busy_n;
    logic r_rw, w_rw_n;
    logic r_first, w_first_n;
    logic r_rx_valid, w_rx_valid_n;
    logic r_rx_first, w_rx_first_n;
    logic r_tx_req, w_tx_req_n;
    logic r_stop, w_stop_n;

    logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
    logic [7:0] w_shift_in;

    // Release is combinational on reset so the bus frees in the reset cycle.
    assign sda_io = (r_sda_low && !rst_i) ? 1'b0 : 1'bz;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_io};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_rise     = w_scl & ~r_scl_d;
    assign w_fall     = ~w_scl & r_scl_d;
    // An SCL edge in the same sample masks any SDA change.
    assign w_start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
    assign w_stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;
    assign w_shift_in = {r_shift[6:0], w_sda};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_bit      <= '0;
            r_shift    <= '0;
            r_tx_sh    <= '0;
            r_rx_data  <= '0;
            r_done     <= 1'b0;
            r_sda_low  <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_first    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            r_tx_req   <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_bit      <= w_bit_n;
            r_shift    <= w_shift_n;
            r_tx_sh    <= w_tx_sh_n;
            r_rx_data  <= w_rx_data_n;
            r_done     <= w_done_n;
            r_sda_low  <= w_sda_low_n;
            r_busy     <= w_busy_n;
            r_rw       <= w_rw_n;
            r_first    <= w_first_n;
            r_rx_valid <= w_rx_valid_n;
            r_rx_first <= w_rx_first_n;
            r_tx_req   <= w_tx_req_n;
            r_stop     <= w_stop_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_bit_n      = r_bit;
        w_shift_n    = r_shift;
        w_tx_sh_n    = r_tx_sh;
        w_rx_data_n  = r_rx_data;
        w_done_n     = r_done;
        w_sda_low_n  = r_sda_low;
        w_busy_n     = r_busy;
        w_rw_n       = r_rw;
        w_first_n    = r_first;
        w_rx_valid_n = 1'b0;
        w_rx_first_n = 1'b0;
        w_tx_req_n   = 1'b0;
        w_stop_n     = 1'b0;
        if (w_stop) begin
            w_state_n   = S_IDLE;
            w_sda_low_n = 1'b0;
            w_stop_n    = r_busy;
            w_busy_n    = 1'b0;
            w_bit_n     = '0;
            w_done_n    = 1'b0;
        end else if (w_start) begin
            w_state_n   = S_ADDR;
            w_sda_low_n = 1'b0;
            w_bit_n     = '0;
            w_done_n    = 1'b0;
            w_shift_n   = '0;
            w_first_n   = 1'b1;
        end else begin
            unique case (r_state)
                S_ADDR: begin
                    if (w_rise) begin
                        w_shift_n = w_shift_in;
                        w_bit_n   = r_bit + 3'd1;
                        w_done_n  = (r_bit == 3'd7);
                    end else if (w_fall && r_done) begin
                        w_done_n = 1'b0;
                        if (r_shift[7:1] == ADDRESS) begin
                            w_state_n   = S_ADDR_ACK;
                            w_sda_low_n = 1'b1;
                            w_busy_n    = 1'b1;
                            w_rw_n      = r_shift[0];
                        end else begin
                            w_state_n = S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_fall) begin
                        w_bit_n = '0;
                        if (r_rw) begin
                            w_state_n   = S_TX;
                            w_tx_req_n  = 1'b1;
                            w_tx_sh_n   = bus_if.tx_data_i[6:0];
                            w_sda_low_n = ~bus_if.tx_data_i[7];
                        end else begin
                            w_state_n   = S_RX;
                            w_sda_low_n = 1'b0;
                        end
                    end
                end
                S_RX: begin
                    if (w_rise) begin
                        w_shift_n = w_shift_in;
                        w_bit_n   = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            w_done_n     = 1'b1;
                            w_rx_data_n  = w_shift_in;
                            w_rx_valid_n = 1'b1;
                            w_rx_first_n = r_first;
                            w_first_n    = 1'b0;
                        end
                    end else if (w_fall && r_done) begin
                        w_state_n   = S_RX_ACK;
                        w_sda_low_n = 1'b1;
                        w_done_n    = 1'b0;
                    end
                end
                S_RX_ACK: begin
                    if (w_fall) begin
                        w_state_n   = S_RX;
                        w_sda_low_n = 1'b0;
                    end
                end
                S_TX: begin
                    if (w_fall) begin
                        if (r_bit == 3'd7) begin
                            w_state_n   = S_TX_ACK;
                            w_sda_low_n = 1'b0;
                            w_bit_n     = '0;
                        end else begin
                            w_sda_low_n = ~r_tx_sh[6];
                            w_tx_sh_n   = {r_tx_sh[5:0], 1'b0};
                            w_bit_n     = r_bit + 3'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (w_rise) begin
                        if (w_sda) begin
                            w_state_n = S_WAIT_STOP;
                            w_busy_n  = 1'b0;
                        end else begin
                            w_done_n = 1'b1;
                        end
                    end else if (w_fall && r_done) begin
                        w_done_n    = 1'b0;
                        w_state_n   = S_TX;
                        w_tx_req_n  = 1'b1;
                        w_tx_sh_n   = bus_if.tx_data_i[6:0];
                        w_sda_low_n = ~bus_if.tx_data_i[7];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_if.rx_data_o  = r_rx_data;
    assign bus_if.rx_valid_o = r_rx_valid;
    assign bus_if.rx_first_o = r_rx_first;
    assign bus_if.tx_req_o   = r_tx_req;
    assign bus_if.busy_o     = r_busy;
    assign bus_if.stop_o     = r_stop;
endmodule
